// File: rtl/uart_echo_ctl.sv
// UART echo controller: 2-flop synchronised RX, echo FIFO, TX gated by sw.
// Optional even parity is selected with `define UART_ECHO_PARITY_EN.
module uart_echo_ctl #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  input  logic              sw,
  output logic [DATA_W-1:0] led,
  output logic              rx_err,
  output logic              overrun,
  output logic              fifo_full,
  output logic [2:0]        rx_state,
  output logic [2:0]        tx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t rx_st;
  state_t tx_st;

  assign rx_state = rx_st;
  assign tx_state = tx_st;

  // Synchroniser plus one extra stage so the falling edge is seen on clean data.
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------- receiver ----------------
  logic [CNT_W-1:0]  rx_cnt;
  logic [BIT_W-1:0]  rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              push_req;
  logic              frame_ok;

`ifdef UART_ECHO_PARITY_EN
  logic rx_par_ok;
  assign frame_ok = rx_sync & rx_par_ok;
`else
  assign frame_ok = rx_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st    <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      push_req <= 1'b0;
      rx_err   <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      rx_par_ok <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_st)
        S_IDLE: begin
          if (rx_fall) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
              rx_st <= S_PAR;
`else
              rx_st <= S_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_ECHO_PARITY_EN
        S_PAR: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt    <= '0;
            rx_par_ok <= ~(^{rx_sync, rx_shift});
            rx_st     <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
            if (frame_ok) push_req <= 1'b1;
            else          rx_err   <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- echo FIFO ----------------
  // push_req is a one-cycle valid with no back-pressure: the word is taken if
  // there is room (or a pop frees a slot in the same cycle), else dropped.
  // pop fires only when TX is idle, sw is high and the FIFO is not empty.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              fifo_empty;
  logic              pop;
  logic              do_push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (tx_st == S_IDLE) && sw && !fifo_empty;
  assign do_push    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      led     <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_req) begin
        led <= rx_shift;
        if (do_push) wr_ptr  <= wr_ptr + 1'b1;
        else         overrun <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  logic [CNT_W-1:0]  tx_cnt;
  logic [BIT_W-1:0]  tx_bit;
  logic [DATA_W-1:0] tx_shift;
`ifdef UART_ECHO_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
`ifdef UART_ECHO_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_st)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            tx_shift <= mem[rd_ptr[AW-1:0]];
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= ^mem[rd_ptr[AW-1:0]];
`endif
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_st    <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx     <= tx_shift[0];
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
              tx    <= tx_par;
              tx_st <= S_PAR;
`else
              tx    <= 1'b1;
              tx_st <= S_STOP;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx       <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_ECHO_PARITY_EN
        S_PAR: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx     <= 1'b1;
            tx_st  <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_st  <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          tx_st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_ctl.sv
// Bench for uart_echo_ctl: serial driver, serial decoder on tx, queue-based
// model of the echo buffer, one task per scenario.
`timescale 1ns/1ps
module tb_uart_echo_ctl;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;
  localparam int DEPTH  = 8;
`ifdef UART_ECHO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + 1;
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic              sw;
  logic              tx;
  logic              rx_err;
  logic              overrun;
  logic              fifo_full;
  logic [DATA_W-1:0] led;
  logic [2:0]        rx_state;
  logic [2:0]        tx_state;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] tx_q[$];
  logic              tx_par_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_echo_ctl #(
    .DATA_W(DATA_W),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .tx(tx),
    .sw(sw),
    .led(led),
    .rx_err(rx_err),
    .overrun(overrun),
    .fifo_full(fifo_full),
    .rx_state(rx_state),
    .tx_state(tx_state)
  );

  // ---------------- tx decoder ----------------
  // Each bit must hold for exactly CPB negedges; words are collected at mid-stop.
  logic              mon_busy = 1'b0;
  int                mon_t    = 0;
  int                mon_err  = 0;
  logic              mon_cur;
  logic [DATA_W-1:0] mon_word;
  logic              mon_par;
  int                mj;
  int                mk;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_t    = 0;
        mon_cur  = 1'b0;
      end
    end else begin
      mon_t++;
      mj = mon_t / CPB;
      mk = mon_t % CPB;
      if (mk == 0) mon_cur = tx;
      else if (tx !== mon_cur) mon_err++;
      if (mk == CPB / 2) begin
        if (mj >= 1 && mj <= DATA_W) begin
          mon_word[mj-1] = tx;
        end else if (PAR_BITS == 1 && mj == DATA_W + 1) begin
          mon_par = tx;
        end else if (mj == FRAME_BITS - 1) begin
          if (tx !== 1'b1) mon_err++;
          else begin
            tx_q.push_back(mon_word);
            tx_par_q.push_back(mon_par);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // rx_err pulse counter and width watch
  int   rx_err_cnt  = 0;
  int   rx_err_wide = 0;
  logic rx_err_d    = 1'b0;

  always @(negedge clk) begin
    if (rx_err === 1'b1) rx_err_cnt++;
    if (rx_err === 1'b1 && rx_err_d === 1'b1) rx_err_wide++;
    rx_err_d = rx_err;
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_bit, input logic par_bit);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) f[1+i] = d[i];
    if (PAR_BITS == 1) f[DATA_W+1] = par_bit;
    f[FRAME_BITS-1] = stop_bit;
    @(negedge clk);
    for (int b = 0; b < FRAME_BITS; b++) begin
      rx = f[b];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (tx_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout frames=%0d want=%0d", tag, tx_q.size(), n);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1)       begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (led !== '0)        begin bad++; $display("FAIL reset_led got=%h want=00", led); end
    total++; if (rx_err !== 1'b0)   begin bad++; $display("FAIL reset_rx_err got=%b want=0", rx_err); end
    total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", fifo_full); end
    total++; if (rx_state !== 3'd0) begin bad++; $display("FAIL reset_rx_state got=%0d want=0", rx_state); end
    total++; if (tx_state !== 3'd0) begin bad++; $display("FAIL reset_tx_state got=%0d want=0", tx_state); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_echo_a5();
    logic [DATA_W-1:0] d;
    d = 8'hA5;
    sw = 1'b1;
    tx_q.delete(); tx_par_q.delete();
    send_frame(d, 1'b1, ^d);
    repeat (2) @(negedge clk);
    total++; if (led !== d) begin bad++; $display("FAIL a5_led got=%h want=%h", led, d); end
    wait_tx(1, 3 * FRAME_CLKS, "a5");
    total++; if (tx_q.size() < 1 || tx_q[0] !== d) begin bad++; $display("FAIL a5_tx got=%h want=%h", tx_q.size() > 0 ? tx_q[0] : 'x, d); end
    total++; if (mon_err !== 0) begin bad++; $display("FAIL a5_bit_width errs=%0d want=0", mon_err); end
`ifdef UART_ECHO_PARITY_EN
    total++; if (tx_par_q.size() < 1 || tx_par_q[0] !== ^d) begin bad++; $display("FAIL a5_par got=%b want=%b", tx_par_q.size() > 0 ? tx_par_q[0] : 1'bx, ^d); end
`endif
  endtask

  task automatic test_back_to_back(input int n);
    logic [DATA_W-1:0] d;
    int err0;
    sw = 1'b1;
    err0 = rx_err_cnt;
    exp_q.delete(); tx_q.delete(); tx_par_q.delete();
    for (int i = 0; i < n; i++) begin
      d = rand_word();
      exp_q.push_back(d);
      send_frame(d, 1'b1, ^d);
      repeat (2) @(negedge clk);
      total++; if (led !== d) begin bad++; $display("FAIL b2b_led[%0d] got=%h want=%h", i, led, d); end
      repeat ($urandom_range(0, 3) * 7) @(negedge clk);
    end
    wait_tx(n, (n + 3) * FRAME_CLKS, "b2b");
    for (int i = 0; i < n; i++) begin
      total++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_tx[%0d] got=%h want=%h", i, i < tx_q.size() ? tx_q[i] : 'x, exp_q[i]);
      end
    end
    total++; if (rx_err_cnt !== err0) begin bad++; $display("FAIL b2b_rx_err got=%0d want=0", rx_err_cnt - err0); end
    total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    total++; if (mon_err !== 0)       begin bad++; $display("FAIL b2b_bit_width errs=%0d want=0", mon_err); end
  endtask

  task automatic test_frame_err();
    logic [DATA_W-1:0] led0;
    logic [DATA_W-1:0] d;
    int err0;
    int wide0;
    d = 8'h3C;
    sw = 1'b1;
    led0 = led; err0 = rx_err_cnt; wide0 = rx_err_wide;
    tx_q.delete();
    send_frame(d, 1'b0, ^d);
    repeat (2 * FRAME_CLKS) @(negedge clk);
    total++; if (rx_err_cnt - err0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", rx_err_cnt - err0); end
    total++; if (rx_err_wide !== wide0)   begin bad++; $display("FAIL ferr_width wide=%0d want=0", rx_err_wide - wide0); end
    total++; if (led !== led0)            begin bad++; $display("FAIL ferr_led got=%h want=%h", led, led0); end
    total++; if (tx_q.size() !== 0)       begin bad++; $display("FAIL ferr_no_echo frames=%0d want=0", tx_q.size()); end
    total++; if (rx_state !== 3'd0)       begin bad++; $display("FAIL ferr_rx_state got=%0d want=0", rx_state); end
  endtask

  task automatic test_glitch();
    logic [DATA_W-1:0] led0;
    int err0;
    led0 = led; err0 = rx_err_cnt;
    tx_q.delete();
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (rx_state !== 3'd0)       begin bad++; $display("FAIL glitch_rx_state got=%0d want=0", rx_state); end
    total++; if (rx_err_cnt !== err0)     begin bad++; $display("FAIL glitch_rx_err got=%0d want=0", rx_err_cnt - err0); end
    repeat (FRAME_CLKS) @(negedge clk);
    total++; if (tx_q.size() !== 0)       begin bad++; $display("FAIL glitch_no_push frames=%0d want=0", tx_q.size()); end
    total++; if (led !== led0)            begin bad++; $display("FAIL glitch_led got=%h want=%h", led, led0); end
  endtask

  task automatic test_sw_gate();
    logic [DATA_W-1:0] d;
    int c;
    sw = 1'b0;
    exp_q.delete(); tx_q.delete();
    for (int i = 0; i < 3; i++) begin
      d = rand_word();
      exp_q.push_back(d);
      send_frame(d, 1'b1, ^d);
    end
    repeat (FRAME_CLKS) @(negedge clk);
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL gate_hold frames=%0d want=0", tx_q.size()); end
    sw = 1'b1;
    c = 0;
    while (tx !== 1'b0 && c < 4 * CPB) begin @(negedge clk); c++; end
    repeat (FRAME_CLKS / 2) @(negedge clk);
    sw = 1'b0;
    repeat (3 * FRAME_CLKS) @(negedge clk);
    total++;
    if (tx_q.size() != 1 || tx_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL gate_midframe frames=%0d want=1 word=%h want=%h", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 'x, exp_q[0]);
    end
    sw = 1'b1;
    wait_tx(3, 5 * FRAME_CLKS, "gate_resume");
    for (int i = 1; i < 3; i++) begin
      total++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL gate_tx[%0d] got=%h want=%h", i, i < tx_q.size() ? tx_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] mdl_q[$];
    logic              ovr_exp;
    int                hi_bad;
    sw = 1'b0;
    ovr_exp = 1'b0;
    tx_q.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      d = rand_word();
      if (mdl_q.size() < DEPTH) mdl_q.push_back(d);
      else ovr_exp = 1'b1;
      send_frame(d, 1'b1, ^d);
      repeat (2) @(negedge clk);
      total++; if (led !== d) begin bad++; $display("FAIL ovf_led[%0d] got=%h want=%h", i, led, d); end
    end
    total++; if (fifo_full !== (mdl_q.size() == DEPTH)) begin bad++; $display("FAIL ovf_full got=%b want=1", fifo_full); end
    total++; if (overrun !== ovr_exp) begin bad++; $display("FAIL ovf_overrun got=%b want=%b", overrun, ovr_exp); end
    sw = 1'b1;
    wait_tx(mdl_q.size(), (DEPTH + 3) * FRAME_CLKS, "ovf_drain");
    for (int i = 0; i < mdl_q.size(); i++) begin
      total++;
      if (i >= tx_q.size() || tx_q[i] !== mdl_q[i]) begin
        bad++; $display("FAIL ovf_tx[%0d] got=%h want=%h", i, i < tx_q.size() ? tx_q[i] : 'x, mdl_q[i]);
      end
    end
    hi_bad = 0;
    repeat (2 * FRAME_CLKS) begin
      @(negedge clk);
      if (tx !== 1'b1) hi_bad++;
    end
    total++; if (hi_bad !== 0) begin bad++; $display("FAIL ovf_idle_high low_cycles=%0d want=0", hi_bad); end
    total++; if (tx_q.size() !== mdl_q.size()) begin bad++; $display("FAIL ovf_extra frames=%0d want=%0d", tx_q.size(), mdl_q.size()); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overrun); end
  endtask

`ifdef UART_ECHO_PARITY_EN
  task automatic test_parity();
    logic [DATA_W-1:0] led0;
    logic [DATA_W-1:0] d;
    int err0;
    d = 8'h07;
    sw = 1'b1;
    led0 = led; err0 = rx_err_cnt;
    tx_q.delete(); tx_par_q.delete();
    send_frame(d, 1'b1, 1'b0);
    repeat (2 * FRAME_CLKS) @(negedge clk);
    total++; if (rx_err_cnt - err0 !== 1) begin bad++; $display("FAIL par_bad_err got=%0d want=1", rx_err_cnt - err0); end
    total++; if (led !== led0)            begin bad++; $display("FAIL par_bad_led got=%h want=%h", led, led0); end
    total++; if (tx_q.size() !== 0)       begin bad++; $display("FAIL par_bad_push frames=%0d want=0", tx_q.size()); end
    send_frame(d, 1'b1, 1'b1);
    wait_tx(1, 3 * FRAME_CLKS, "par_good");
    total++; if (tx_q.size() < 1 || tx_q[0] !== d)        begin bad++; $display("FAIL par_good_tx got=%h want=%h", tx_q.size() > 0 ? tx_q[0] : 'x, d); end
    total++; if (tx_par_q.size() < 1 || tx_par_q[0] !== 1'b1) begin bad++; $display("FAIL par_good_bit got=%b want=1", tx_par_q.size() > 0 ? tx_par_q[0] : 1'bx); end
    total++; if (led !== d) begin bad++; $display("FAIL par_good_led got=%h want=%h", led, d); end
  endtask
`endif

  task automatic test_reset_mid_tx();
    logic [DATA_W-1:0] d;
    int c;
    sw = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      d = rand_word();
      send_frame(d, 1'b1, ^d);
    end
    repeat (2) @(negedge clk);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL rmid_pre_overrun got=%b want=1", overrun); end
    tx_q.delete();
    sw = 1'b1;
    c = 0;
    while (!(mon_busy && mon_t >= 4 * CPB + 3) && c < 3 * FRAME_CLKS) begin @(negedge clk); c++; end
    total++; if (!(mon_busy && mon_t >= 4 * CPB + 3)) begin bad++; $display("FAIL rmid_reach_bit3 t=%0d want=%0d", mon_t, 4 * CPB + 3); end
    rst = 1'b0;
    #1;
    total++; if (tx !== 1'b1)        begin bad++; $display("FAIL rmid_tx got=%b want=1", tx); end
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL rmid_overrun got=%b want=0", overrun); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b want=0", fifo_full); end
    total++; if (led !== '0)         begin bad++; $display("FAIL rmid_led got=%h want=00", led); end
    total++; if (tx_state !== 3'd0)  begin bad++; $display("FAIL rmid_tx_state got=%0d want=0", tx_state); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tx_q.delete();
    repeat (2 * FRAME_CLKS) @(negedge clk);
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL rmid_empty frames=%0d want=0", tx_q.size()); end
    d = rand_word();
    send_frame(d, 1'b1, ^d);
    wait_tx(1, 3 * FRAME_CLKS, "rmid_after");
    total++; if (tx_q.size() < 1 || tx_q[0] !== d) begin bad++; $display("FAIL rmid_echo got=%h want=%h", tx_q.size() > 0 ? tx_q[0] : 'x, d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    sw  = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_echo_a5();
    test_back_to_back(6);
    test_frame_err();
    test_glitch();
    test_sw_gate();
    test_overflow();
`ifdef UART_ECHO_PARITY_EN
    test_parity();
`endif
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctl.md
UART_ECHO_CTL -- requirements
Module: uart_echo_ctl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: serial data bits per frame, legal range 5..8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per bit, even, at least 8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: echo buffer entries, a power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial input, idle high.
REQ-007 SHALL have port tx, output, 1 bit: serial output, idle high.
REQ-008 SHALL have port sw, input, 1 bit: echo enable; level, treated as synchronous.
REQ-009 SHALL have port led, output, DATA_W bits: last valid received word.
REQ-010 SHALL have port rx_err, output, 1 bit: one-cycle pulse on a framing error or a parity error.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a word is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_full, output, 1 bit: FIFO holds FIFO_DEPTH words.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-014 RX FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-015 RX SHALL leave IDLE on a synchronised 1->0 edge and check the start bit at CLKS_PER_BIT/2; if rx is high there, RX SHALL return to IDLE with no error.
REQ-016 RX SHALL sample the DATA_W data bits LSB first, one per CLKS_PER_BIT, at mid-bit.
REQ-017 A stop bit sampled as 0 SHALL discard the word, pulse rx_err, and return RX to IDLE.
REQ-018 A valid word SHALL be pushed to the FIFO, and led SHALL update, in the cycle after the stop-bit sample.
REQ-019 A push to a full FIFO SHALL drop the word and set overrun, and led SHALL still update; a push and a pop in the same cycle on a full FIFO SHALL accept the push.
REQ-020 The FIFO SHALL use wrapping pointers with log2(FIFO_DEPTH)+1 bits; full and empty SHALL be decoded from the pointer MSB and equality; there SHALL be no pop when empty.
REQ-021 TX FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-022 In IDLE with sw=1 and the FIFO non-empty, TX SHALL pop one word and drive the start bit from the next cycle.
REQ-023 TX SHALL send each bit for exactly CLKS_PER_BIT cycles, LSB first, then one stop bit (1), and return to IDLE.
REQ-024 sw falling mid-frame SHALL NOT abort the current frame; no new frame SHALL start while sw=0.
REQ-025 RX and TX SHALL run independently; full duplex SHALL be supported.

Reset
REQ-026 rst low SHALL asynchronously force: tx=1, led=0, rx_err=0, overrun=0, FIFO empty, both FSMs IDLE, all counters 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, RX SHALL wait for a fresh falling edge.

Configuration
REQ-028 Macro UART_ECHO_PARITY_EN SHALL select parity support.
REQ-029 With UART_ECHO_PARITY_EN defined, frames SHALL carry an even-parity bit after the data (PAR state); an RX mismatch SHALL discard the word and pulse rx_err, and TX SHALL generate the bit.
REQ-030 With UART_ECHO_PARITY_EN undefined, the PAR states SHALL be skipped and no parity logic SHALL be synthesised.

Verification
REQ-031 Defaults, sw=1, rx frame 0xA5 -> led=0xA5 after the stop bit; tx emits 0xA5 frame, each bit 16 clk wide.
REQ-032 sw=0, send 9 words 0x01..0x09 -> fifo_full=1, overrun=1, led=0x09; sw=1 -> tx emits 0x01..0x08 in order, then idles high.
REQ-033 rx 0x3C frame with stop bit=0 -> rx_err 1-cycle pulse, FIFO unchanged, led unchanged.
REQ-034 rx low glitch of 4 clk -> no error, no push, RX back in IDLE.
REQ-035 Assert rst during tx DATA bit 3 -> tx=1 immediately, FIFO empty, overrun=0; next frame after release echoes correctly.
REQ-036 With UART_ECHO_PARITY_EN, rx 0x07 with parity bit 0 -> rx_err pulse and no push; 0x07 with parity bit 1 -> echoed with parity bit 1.
